// File: rtl/acc32_stream.sv
// Streaming frame accumulator: sums LEN unsigned 32-bit words per frame through a 4-bit CLA chain adder.
// Optional ACC32_SAT_EN: saturate the frame sum at 32'hFFFFFFFF on any carry-out instead of wrapping.

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a_i ^ b_i;
    assign w_g = a_i & b_i;

    assign w_c[0] = c_i;
    assign w_c[1] = w_g[0] | (w_p[0] & c_i);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_i);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_i);
    assign c_o    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_i);

    assign sum_o = w_p ^ w_c;
endmodule

module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] sum_o,
    output logic        c_o
);
    logic [8:0] w_c;

    assign w_c[0] = c_i;

    // Eight CLA groups rippling group carries.
    for (genvar g = 0; g < 8; g++) begin : g_cla
        cla4 u_cla4 (
            .a_i  (a_i[4*g +: 4]),
            .b_i  (b_i[4*g +: 4]),
            .c_i  (w_c[g]),
            .sum_o(sum_o[4*g +: 4]),
            .c_o  (w_c[g+1])
        );
    end

    assign c_o = w_c[8];
endmodule

module acc32_stream #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_ovf,
    output logic        busy
);
    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [31:0]        r_out_sum;
    logic               r_out_ovf;

    logic [31:0]        w_sum;
    logic               w_co;
    logic [31:0]        w_acc_nxt;
    logic               w_ovf_nxt;
    logic               w_fire;
    logic               w_last;

    adder32 u_adder32 (
        .a_i  (r_acc),
        .b_i  (in_data),
        .c_i  (1'b0),
        .sum_o(w_sum),
        .c_o  (w_co)
    );

`ifdef ACC32_SAT_EN
    // A saturated acc plus any nonzero word carries out, so c_o alone keeps it pinned.
    assign w_acc_nxt = w_co ? 32'hFFFF_FFFF : w_sum;
`else
    assign w_acc_nxt = w_sum;
`endif
    assign w_ovf_nxt = r_ovf | w_co;
    assign w_fire    = in_valid & in_ready;
    assign w_last    = (r_cnt == CNT_W'(LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ACC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_ACC: begin
                in_ready = ~clr;
                if (in_valid && !clr && w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_ACC;
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else if (r_state == S_ACC) begin
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_fire) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                r_ovf <= w_ovf_nxt;
                if (w_last) begin
                    r_out_sum <= w_acc_nxt;
                    r_out_ovf <= w_ovf_nxt;
                end
            end
        end else if (out_ready) begin
            // clr is ignored in DONE; only the handshake releases the frame state.
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign busy      = (r_cnt != '0) || (r_state == S_DONE);
endmodule

// File: doc/acc32_stream.md
Name: acc32_stream

Overview:
- Streaming 32-bit accumulator. Sums fixed-length frames of LEN unsigned words and sits directly upstream of the datapath consumer.
- Internally instantiates one adder32 (4-bit CLA chain) as its only arithmetic element.
- Input side is a valid/ready stream. Output side presents one result word per frame under valid/ready.
- Serves as the frame-sum stage feeding checksum/statistics logic.

Parameters:
- LEN, 8: words per frame; legal range 2..256.
- CNT_W, 8: width of the word counter; must satisfy 2^CNT_W >= LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous frame abort; discards the partial sum.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  32  unsigned input word.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  32  frame sum.
- out_ovf  out  1  at least one carry-out occurred during the frame.
- busy  out  1  a frame is in progress (count != 0) or a result is pending.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of clk. No asynchronous paths.
- Reset values: state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- States:
  - ACC: in_ready=1 unless clr is asserted.
  - DONE: in_ready=0, out_valid=1.
- Accept rule: a word is accepted on a clk edge with in_valid && in_ready. On accept:
  - acc <= adder32(acc, in_data, c_in=0).sum_o
  - ovf <= ovf | c_o
  - cnt <= cnt+1
- Frame end: the accept with cnt==LEN-1 moves the block to DONE.
  - out_sum and out_ovf are registered from the updated values.
  - out_valid rises on the edge after the LEN-th accept (latency 1 clk).
- Back-to-back: in_data may be accepted every cycle in ACC. Throughput is LEN words per LEN+1 cycles minimum (one DONE cycle per frame when out_ready=1).
- DONE to ACC: on out_valid && out_ready, clear acc, cnt and ovf in the same edge, drop out_valid, and return to ACC. in_ready is 0 during that cycle, so no word of the next frame is accepted early.
- Output hold: out_sum and out_ovf stay stable while out_valid=1 && out_ready=0. They keep their last value after the handshake until the next frame completes.
- clr:
  - Asserted in ACC: acc, cnt and ovf are cleared at the edge. in_ready is forced 0 combinationally, so a simultaneous in_valid word is dropped and not counted.
  - Asserted in DONE: ignored; a pending result is never lost.
- Reset mid-frame: the partial sum is discarded and all registers return to reset values. No output is produced for that frame.
- Arithmetic: unsigned modulo 2^32. out_ovf is sticky over the frame: OR of every adder c_o.
- busy = (cnt != 0) || (state == DONE).

Optional Feature:
- Macro ACC32_SAT_EN.
- Defined:
  - On any accept whose adder c_o=1, acc <= 32'hFFFFFFFF and ovf <= 1.
  - Once acc is saturated, further words in the frame are still accepted and counted, but acc holds at 32'hFFFFFFFF.
  - out_sum of an overflowed frame is therefore 32'hFFFFFFFF.
- Not defined:
  - Wrap-around modulo 2^32; out_ovf is still reported.
  - No saturation logic is synthesised.

Test Plan:
- Basic frame: LEN=8, words 1..8 streamed back-to-back, out_ready=1. Expect out_valid exactly 1 clk after the 8th accept, out_sum=36, out_ovf=0, in_ready=0 for that cycle, next frame accepted the following cycle.
- Overflow: frame of 8 × 32'h4000_0000. Without ACC32_SAT_EN: out_sum=32'h0000_0000, out_ovf=1. With ACC32_SAT_EN: out_sum=32'hFFFF_FFFF, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, with in_valid held 1. Expect in_ready=0, out_sum stable for all 5 cycles, no extra word accepted. First word accepted one cycle after the out_ready=1 handshake.
- Abort: 3 words (10, 20, 30) accepted, then clr=1 with in_valid=1 and in_data=99. Expect the 99 word dropped, cnt=0, busy=0. A following frame of 8 × 1 yields out_sum=8, out_ovf=0.
- Reset mid-frame: accept 5 words, assert rst for 1 cycle. Expect all outputs at reset values next cycle and no out_valid for the aborted frame. Next full frame sums correctly.
- Carry chain: frame [32'h0000_000F, 32'h0000_0001, 32'h0FFF_FFF0, 0, 0, 0, 0, 0]. Expect out_sum=32'h1000_0000, out_ovf=0, which checks carry propagation through all eight 4-bit CLA groups.
